// File: rtl/cred_vault_ctrl.sv
// rtl/cred_vault_ctrl.sv - credential vault controller: tag CAM with cipher and flash sequencing
module cred_vault_ctrl #(
  parameter int                DATA_W     = 128,
  parameter int                ADDR_WIDTH = 4,
  parameter logic [DATA_W-1:0] LOCAL_KEY  = 128'h5468617473206D79204B756E67204675
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_W-1:0]     cmd_account,
  input  logic [DATA_W-1:0]     cmd_pass,
  input  logic                  key_sel,
  input  logic [DATA_W-1:0]     master_key,
  output logic                  cph_start,
  output logic                  cph_decrypt,
  output logic [DATA_W-1:0]     cph_din,
  output logic [DATA_W-1:0]     cph_key,
  input  logic                  cph_done,
  input  logic [DATA_W-1:0]     cph_dout,
  output logic [ADDR_WIDTH-1:0] fl_addr,
  output logic                  fl_rd_en,
  input  logic                  fl_rvalid,
  input  logic [2*DATA_W-1:0]   fl_rdata,
  output logic                  fl_wr_en,
  output logic [2*DATA_W-1:0]   fl_wdata,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_status,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_STORE  = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_MISS = 2'b01;
  localparam logic [1:0] ST_FULL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_MATCH, S_FL_RD, S_DEC, S_ENC, S_FL_WR, S_RSP
  } state_t;

  state_t state, state_n;

  logic [1:0]            op_q;
  logic [DATA_W-1:0]     acct_q, pass_q;
  logic                  ksel_q;
  logic [DATA_W-1:0]     tags [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH-1:0] tgt_q;
  logic                  was_hit_q;
  logic                  issued_q;
  logic [DATA_W-1:0]     din_q, key_q;
  logic [2*DATA_W-1:0]   wdata_q;
  logic [1:0]            rsp_status_q;
  logic [DATA_W-1:0]     rsp_data_q;
  logic [ADDR_WIDTH-1:0] rsp_addr_q;

  logic                  hit, free_ok;
  logic [ADDR_WIDTH-1:0] hit_idx, free_idx;
  logic [1:0]            rsp_st_n;
  logic [DATA_W-1:0]     rsp_dat_n;
  logic [ADDR_WIDTH-1:0] rsp_adr_n;

  // Descending scan so the lowest matching / free index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && tags[i] == acct_q) begin
        hit     = 1'b1;
        hit_idx = i[ADDR_WIDTH-1:0];
      end
      if (!valid_q[i]) begin
        free_ok  = 1'b1;
        free_idx = i[ADDR_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n     = state;
    rsp_st_n    = ST_OK;
    rsp_dat_n   = '0;
    rsp_adr_n   = '0;
    cmd_ready   = 1'b0;
    cph_start   = 1'b0;
    cph_decrypt = 1'b0;
    fl_rd_en    = 1'b0;
    fl_wr_en    = 1'b0;
    rsp_valid   = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_n = S_MATCH;
      end
      S_MATCH: begin
        case (op_q)
          OP_LOOKUP: begin
            if (hit) state_n = S_FL_RD;
            else begin
              state_n  = S_RSP;
              rsp_st_n = ST_MISS;
            end
          end
          OP_STORE: begin
            if (hit || free_ok) state_n = S_ENC;
            else begin
              state_n  = S_RSP;
              rsp_st_n = ST_FULL;
            end
          end
          OP_DELETE: begin
            state_n = S_RSP;
            if (hit) rsp_adr_n = hit_idx;
            else     rsp_st_n  = ST_MISS;
          end
          default: state_n = S_RSP;
        endcase
      end
      S_FL_RD: begin
        fl_rd_en = !issued_q;
        if (fl_rvalid) begin
          // A stale or foreign flash record must not be decrypted as ours.
          if (fl_rdata[2*DATA_W-1:DATA_W] == acct_q) state_n = S_DEC;
          else begin
            state_n  = S_RSP;
            rsp_st_n = ST_MISS;
          end
        end
      end
      S_DEC: begin
        cph_start   = !issued_q;
        cph_decrypt = 1'b1;
        if (cph_done) state_n = S_ENC;
      end
      S_ENC: begin
        cph_start = !issued_q;
        if (cph_done) begin
          if (op_q == OP_STORE) state_n = S_FL_WR;
          else begin
            state_n   = S_RSP;
            rsp_dat_n = cph_dout;
            rsp_adr_n = tgt_q;
          end
        end
      end
      S_FL_WR: begin
        fl_wr_en  = 1'b1;
        state_n   = S_RSP;
        rsp_adr_n = tgt_q;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == S_FL_WR) tags[tgt_q] <= acct_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q         <= '0;
      acct_q       <= '0;
      pass_q       <= '0;
      ksel_q       <= 1'b0;
      valid_q      <= '0;
      count_q      <= '0;
      tgt_q        <= '0;
      was_hit_q    <= 1'b0;
      issued_q     <= 1'b0;
      din_q        <= '0;
      key_q        <= '0;
      wdata_q      <= '0;
      rsp_status_q <= '0;
      rsp_data_q   <= '0;
      rsp_addr_q   <= '0;
    end else begin
      // Start/read strobes fire only on the first cycle of each waiting state.
      issued_q <= (state_n == state);
      if (state_n == S_RSP) begin
        rsp_status_q <= rsp_st_n;
        rsp_data_q   <= rsp_dat_n;
        rsp_addr_q   <= rsp_adr_n;
      end
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            acct_q <= cmd_account;
            pass_q <= cmd_pass;
            ksel_q <= key_sel;
          end
        end
        S_MATCH: begin
          tgt_q     <= hit ? hit_idx : free_idx;
          was_hit_q <= hit;
          case (op_q)
            OP_STORE: begin
              din_q <= pass_q;
              key_q <= LOCAL_KEY;
            end
            OP_DELETE: begin
              if (hit) begin
                valid_q[hit_idx] <= 1'b0;
                count_q          <= count_q - CNT_ONE;
              end
            end
            OP_LOOKUP: ;
            default: begin
              valid_q <= '0;
              count_q <= '0;
            end
          endcase
        end
        S_FL_RD: begin
          if (fl_rvalid) begin
            din_q <= fl_rdata[DATA_W-1:0];
            key_q <= LOCAL_KEY;
          end
        end
        S_DEC: begin
          if (cph_done) begin
            din_q <= cph_dout;
            key_q <= ksel_q ? master_key : LOCAL_KEY;
          end
        end
        S_ENC: begin
          if (cph_done) wdata_q <= {acct_q, cph_dout};
        end
        S_FL_WR: begin
          valid_q[tgt_q] <= 1'b1;
          if (!was_hit_q) count_q <= count_q + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign cph_din    = din_q;
  assign cph_key    = key_q;
  assign fl_addr    = tgt_q;
  assign fl_wdata   = wdata_q;
  assign rsp_status = rsp_status_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_addr   = rsp_addr_q;
  assign count      = count_q;
  assign full       = (count_q == CNT_FULL);

endmodule

// File: tb/tb_cred_vault_ctrl.sv
// tb/tb_cred_vault_ctrl.sv - bench for cred_vault_ctrl with XOR cipher and 2-cycle flash models
module tb_cred_vault_ctrl;

  localparam logic [127:0] LK = 128'h5468617473206D79204B756E67204675;
  localparam logic [1:0] LOOKUP = 2'b00, STORE = 2'b01, DELETE = 2'b10, CLEAR = 2'b11;
  localparam logic [1:0] OK = 2'b00, MISS = 2'b01, FULLST = 2'b10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0, cmd_ready;
  logic [1:0]   cmd_op = '0;
  logic [127:0] cmd_account = '0, cmd_pass = '0, master_key = '0;
  logic         key_sel = 1'b0;
  logic         cph_start, cph_decrypt, cph_done;
  logic [127:0] cph_din, cph_key, cph_dout;
  logic [3:0]   fl_addr;
  logic         fl_rd_en, fl_rvalid, fl_wr_en;
  logic [255:0] fl_rdata, fl_wdata;
  logic         rsp_valid;
  logic [1:0]   rsp_status;
  logic [127:0] rsp_data;
  logic [3:0]   rsp_addr;
  logic [4:0]   count;
  logic         full;

  cred_vault_ctrl #(.DATA_W(128), .ADDR_WIDTH(4), .LOCAL_KEY(LK)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_account(cmd_account), .cmd_pass(cmd_pass), .key_sel(key_sel), .master_key(master_key),
    .cph_start(cph_start), .cph_decrypt(cph_decrypt), .cph_din(cph_din), .cph_key(cph_key),
    .cph_done(cph_done), .cph_dout(cph_dout), .fl_addr(fl_addr), .fl_rd_en(fl_rd_en),
    .fl_rvalid(fl_rvalid), .fl_rdata(fl_rdata), .fl_wr_en(fl_wr_en), .fl_wdata(fl_wdata),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .count(count), .full(full)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total = 0;
  int mon_wr = 0, mon_st = 0, mon_rd = 0;
  logic [255:0] fmem [16];
  logic [255:0] tamper = '0;

  // Cipher: XOR with key, result 11 cycles after the start pulse.
  initial begin : cipher_model
    int cnt;
    logic [127:0] res;
    cnt = 0; res = '0; cph_done = 1'b0; cph_dout = '0;
    forever begin
      @(negedge clk);
      cph_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin cph_done = 1'b1; cph_dout = res; end
      end
      if (cph_start) begin res = cph_din ^ cph_key; cnt = 11; end
    end
  end

  initial begin : flash_model
    int rcnt;
    logic [3:0] raddr;
    rcnt = 0; raddr = '0; fl_rvalid = 1'b0; fl_rdata = '0;
    forever begin
      @(negedge clk);
      fl_rvalid = 1'b0;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin fl_rvalid = 1'b1; fl_rdata = fmem[raddr] ^ tamper; end
      end
      if (fl_wr_en) fmem[fl_addr] = fl_wdata;
      if (fl_rd_en) begin raddr = fl_addr; rcnt = 2; end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (fl_wr_en)  mon_wr++;
      if (cph_start) mon_st++;
      if (fl_rd_en)  mon_rd++;
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic send(input logic [1:0] op, input logic [127:0] a, input logic [127:0] p,
                      input logic ks, input logic [127:0] mk);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("ready_timeout", 0, 1);
    cmd_op = op; cmd_account = a; cmd_pass = p; key_sel = ks; master_key = mk; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); key_sel = 1'($urandom);
    cmd_account = {$urandom, $urandom, $urandom, $urandom};
    cmd_pass = {$urandom, $urandom, $urandom, $urandom};
    mon_wr = 0; mon_st = 0; mon_rd = 0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [127:0] a, input logic [127:0] p,
                        input logic ks, input logic [127:0] mk, output logic [1:0] st,
                        output logic [3:0] ad, output logic [127:0] dt, output int lat);
    send(op, a, p, ks, mk);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 300);
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
    st = rsp_status; ad = rsp_addr; dt = rsp_data;
  endtask

  // Reference vault: plaintext passwords kept per slot, cipher reduced to XOR algebra.
  logic [127:0] mtag [16], mpass [16];
  bit           mval [16];

  task automatic model(input logic [1:0] op, input logic [127:0] a, input logic [127:0] p,
                       input logic ks, input logic [127:0] mk, output logic [1:0] st,
                       output logic [3:0] ad, output logic [127:0] dt, output int cnt);
    int h, f;
    h = -1; f = -1;
    for (int i = 15; i >= 0; i--) begin
      if (mval[i] && mtag[i] == a) h = i;
      if (!mval[i]) f = i;
    end
    st = OK; ad = '0; dt = '0;
    case (op)
      LOOKUP: if (h >= 0) begin ad = 4'(h); dt = mpass[h] ^ (ks ? mk : LK); end else st = MISS;
      STORE: begin
        if (h < 0) h = f;
        if (h >= 0) begin ad = 4'(h); mval[h] = 1; mtag[h] = a; mpass[h] = p; end
        else st = FULLST;
      end
      DELETE: if (h >= 0) begin ad = 4'(h); mval[h] = 0; end else st = MISS;
      default: for (int i = 0; i < 16; i++) mval[i] = 0;
    endcase
    cnt = 0;
    for (int i = 0; i < 16; i++) cnt += mval[i];
  endtask

  typedef struct {
    logic [1:0] op; logic [127:0] a; logic [127:0] p; logic ks; logic [127:0] mk;
    logic [1:0] st; logic [3:0] ad; logic [127:0] dt; int cnt; int lat; int wr; int cs;
  } vec_t;

  function automatic vec_t mkv(logic [1:0] op, logic [127:0] a, logic [127:0] p, logic ks,
                               logic [127:0] mk, logic [1:0] st, logic [3:0] ad,
                               logic [127:0] dt, int cnt, int lat, int wr, int cs);
    vec_t v;
    v.op = op; v.a = a; v.p = p; v.ks = ks; v.mk = mk; v.st = st; v.ad = ad; v.dt = dt;
    v.cnt = cnt; v.lat = lat; v.wr = wr; v.cs = cs;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    logic [1:0] st, est;
    logic [3:0] ad, ead;
    logic [127:0] dt, edt, a, p, mk;
    logic ks;
    int lat, ecnt, n, seen, acc, rsps, r;
    logic [1:0] op;

    tbl.push_back(mkv(STORE, 'hA1, 'h55, 0, 0, OK, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mkv(LOOKUP, 'hA1, 0, 1, 'hF0, OK, 0, 128'h55 ^ 128'hF0, 1, 0, 0, 2));
    tbl.push_back(mkv(LOOKUP, 'hA1, 0, 0, 'hF0, OK, 0, 128'h55 ^ LK, 1, 0, 0, 2));
    tbl.push_back(mkv(LOOKUP, 'hB2, 0, 0, 0, MISS, 0, 0, 1, 2, 0, 0));
    for (int i = 1; i < 16; i++)
      tbl.push_back(mkv(STORE, 128'(i), 128'(i * 3), 0, 0, OK, 4'(i), 0, i + 1, 0, 1, 1));
    tbl.push_back(mkv(STORE, 'hEE, 'h1, 0, 0, FULLST, 0, 0, 16, 2, 0, 0));
    tbl.push_back(mkv(STORE, 'h05, 'h99, 0, 0, OK, 5, 0, 16, 0, 1, 1));
    tbl.push_back(mkv(LOOKUP, 'h05, 0, 0, 0, OK, 5, 128'h99 ^ LK, 16, 0, 0, 2));
    tbl.push_back(mkv(DELETE, 'h03, 0, 0, 0, OK, 3, 0, 15, 2, 0, 0));
    tbl.push_back(mkv(STORE, 'h77, 'h12, 0, 0, OK, 3, 0, 16, 0, 1, 1));
    tbl.push_back(mkv(LOOKUP, 'h77, 0, 1, 'h1234, OK, 3, 128'h12 ^ 128'h1234, 16, 0, 0, 2));
    tbl.push_back(mkv(DELETE, 'h03, 0, 0, 0, MISS, 0, 0, 16, 2, 0, 0));
    tbl.push_back(mkv(CLEAR, 0, 0, 0, 0, OK, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mkv(LOOKUP, 'hA1, 0, 1, 'hF0, MISS, 0, 0, 0, 2, 0, 0));

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cph_start", cph_start, 0);
    chk("rst_fl_wr_en", fl_wr_en, 0);
    chk("rst_fl_rd_en", fl_rd_en, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst = 1'b1;

    // Reset landing in the middle of an encrypt.
    do_cmd(STORE, 'h11, 'h22, 0, 0, st, ad, dt, lat);
    chk("pre_rst_count", count, 1);
    send(STORE, 'h33, 'h44, 0, 0);
    n = 0;
    while (!cph_start && n < 50) begin @(negedge clk); n++; end
    chk("enc_started", cph_start, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0; #1;
    chk("midenc_count", count, 0);
    chk("midenc_cmd_ready", cmd_ready, 1);
    chk("midenc_cph_start", cph_start, 0);
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid || cph_start || fl_wr_en || !cmd_ready) seen = 1;
    end
    chk("late_done_ignored", seen, 0);
    do_cmd(LOOKUP, 'h11, 0, 0, 0, st, ad, dt, lat);
    chk("post_rst_lookup", st, MISS);
    chk("post_rst_lat", lat, 2);

    foreach (tbl[i]) begin
      do_cmd(tbl[i].op, tbl[i].a, tbl[i].p, tbl[i].ks, tbl[i].mk, st, ad, dt, lat);
      chk($sformatf("v%0d_status", i), st, tbl[i].st);
      chk($sformatf("v%0d_addr", i), ad, tbl[i].ad);
      chk($sformatf("v%0d_data", i), dt, tbl[i].dt);
      chk($sformatf("v%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("v%0d_full", i), full, tbl[i].cnt == 16);
      chk($sformatf("v%0d_wr_pulses", i), mon_wr, tbl[i].wr);
      chk($sformatf("v%0d_cph_starts", i), mon_st, tbl[i].cs);
      if (tbl[i].lat != 0) chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      if (tbl[i].op == STORE && tbl[i].st == OK)
        chk($sformatf("v%0d_flash_word", i), fmem[tbl[i].ad], {tbl[i].a, tbl[i].p ^ LK});
      @(negedge clk);
      chk($sformatf("v%0d_rsp_one_cycle", i), rsp_valid, 0);
      chk($sformatf("v%0d_rsp_held", i), {rsp_status, rsp_data}, {tbl[i].st, tbl[i].dt});
    end

    // Flash record whose tag half no longer matches the CAM.
    do_cmd(STORE, 'h2A, 'h7, 0, 0, st, ad, dt, lat);
    chk("tamper_store", {st, ad}, {OK, 4'd0});
    tamper = {128'h1, 128'h0};
    do_cmd(LOOKUP, 'h2A, 0, 0, 0, st, ad, dt, lat);
    chk("tamper_status", st, MISS);
    chk("tamper_reads", mon_rd, 1);
    chk("tamper_no_cipher", mon_st, 0);
    tamper = '0;
    do_cmd(LOOKUP, 'h2A, 0, 0, 0, st, ad, dt, lat);
    chk("untamper_data", {st, dt}, {OK, 128'h7 ^ LK});
    do_cmd(CLEAR, 0, 0, 0, 0, st, ad, dt, lat);
    for (int i = 0; i < 16; i++) mval[i] = 0;

    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 19);
      op = (r < 8) ? STORE : (r < 13) ? LOOKUP : (r < 18) ? DELETE : CLEAR;
      a  = 128'h100 + 128'($urandom_range(0, 19));
      p  = {$urandom, $urandom, $urandom, $urandom};
      mk = {$urandom, $urandom, $urandom, $urandom};
      ks = 1'($urandom_range(0, 1));
      model(op, a, p, ks, mk, est, ead, edt, ecnt);
      do_cmd(op, a, p, ks, mk, st, ad, dt, lat);
      chk($sformatf("r%0d_status", i), st, est);
      chk($sformatf("r%0d_addr", i), ad, ead);
      chk($sformatf("r%0d_data", i), dt, edt);
      chk($sformatf("r%0d_count", i), count, ecnt);
    end

    // cmd_valid held high across two back-to-back CLEARs.
    @(negedge clk);
    while (!cmd_ready) @(negedge clk);
    cmd_op = CLEAR; cmd_valid = 1'b1;
    acc = 0; rsps = 0;
    for (int i = 0; i < 6; i++) begin
      if (cmd_valid && cmd_ready) acc++;
      if (rsp_valid) rsps++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("held_accepts", acc, 2);
    chk("held_responses", rsps, 2);
    chk("held_count", count, 0);
    chk("held_full", full, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
